ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Sits between the PS/2 keyboard interface and the UART transmitter.
- Consumes raw Set-2 scan code bytes from the keyboard interface and tracks make/break, E0 and E1 prefix sequences, Shift state and lock-key state.
- Emits one ASCII byte per printable key press through a valid/ready handshake to the UART stage.
- Drives the 3-bit lock-LED status back toward the keyboard interface.

Parameters:
- E1_SKIP, 7: number of bytes discarded after an E1 (Pause) prefix byte.

Ports:
- i_clk  input  1  system clock; the only clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_scancode  input  8  scan code byte from the keyboard interface.
- i_scan_valid  input  1  one-cycle strobe; i_scancode is valid on this cycle.
- o_ascii  output  8  decoded ASCII character.
- o_ascii_valid  output  1  o_ascii holds an undelivered character.
- i_ascii_ready  input  1  downstream accepts o_ascii on a cycle where o_ascii_valid=1 and this is 1.
- o_led_status  output  3  [0]=Scroll Lock, [1]=Num Lock, [2]=Caps Lock.
- o_drop  output  1  one-cycle pulse: a decoded character was lost to backpressure.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, o_ascii=0x00, o_ascii_valid=0, o_led_status=3'b000, o_drop=0, both shift flags=0, all lock-held flags=0, skip counter=0.
- All state updates occur only on cycles with i_scan_valid=1.
- FSM states:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP (counter loaded with E1_SKIP); any other byte is processed as a make code and the FSM stays in IDLE.
  - BRK: the byte is processed as a break code, then ->IDLE.
  - EXT: F0->EXT_BRK; any other byte is ignored, ->IDLE.
  - EXT_BRK: the byte is ignored, ->IDLE.
  - SKIP: counter decrements on each byte; ->IDLE on the byte where the counter reaches 0. No decode occurs in SKIP.
- Extended (E0) keys never produce output and never modify shift or lock state.
- Shift:
  - 0x12 = left Shift, 0x59 = right Shift; each has its own held flag.
  - A make code sets the flag; a break code clears it.
  - shift = left OR right.
- Locks:
  - Caps 0x58, Num 0x77, Scroll 0x7E.
  - On a make code, toggle the matching LED bit only if that key's held flag is 0, then set the held flag. Typematic repeats therefore do not toggle.
  - A break code clears the held flag.
  - o_led_status updates on the cycle after the make byte.
- Character map (make codes only):
  - Letters: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A. Output is uppercase when shift XOR caps, lowercase otherwise.
  - Digits 1-9,0 = 16 1E 26 25 2E 36 3D 3E 46 45. Unshifted gives '1'..'9','0'. Shifted gives ! @ # $ % ^ & * ( ). Caps Lock has no effect on digits.
  - Fixed codes, independent of shift: 0x29->0x20, 0x5A->0x0D, 0x66->0x08, 0x0D->0x09, 0x76->0x1B.
  - Any other make code produces no output.
- Output register:
  - A decoded character loads o_ascii and sets o_ascii_valid on the next cycle, i.e. latency 1 clock from the make byte strobe.
  - o_ascii and o_ascii_valid are held stable while o_ascii_valid=1 and i_ascii_ready=0.
  - Handshake completes on a cycle with o_ascii_valid=1 and i_ascii_ready=1. o_ascii_valid clears next cycle unless a new character is loaded on that same cycle, in which case the new character replaces it and valid stays 1.
  - If a new character is decoded while o_ascii_valid=1 and i_ascii_ready=0: the new character is discarded, the held character is unchanged, and o_drop pulses for 1 cycle. Shift and lock side effects still apply.
- Reset mid-sequence (for example after F0 or during SKIP) returns the FSM to IDLE immediately. The next byte is decoded as a fresh make code.

Test Plan:
- Byte 0x1C with i_ascii_ready=1 -> o_ascii=0x61 with o_ascii_valid high for exactly 1 cycle, 1 clock after the strobe. Then bytes F0,1C -> no further o_ascii_valid.
- Bytes 12,1C,F0,12,1C -> outputs 0x41 then 0x61. Bytes 59,16 -> output 0x21.
- Bytes 58,58,F0,58 -> o_led_status=3'b100 (a single toggle despite the repeat). Then 1C -> 0x41. Then 12,1C -> 0x61.
- Bytes E0,75,E0,F0,75 -> no output, o_led_status and shift state unchanged. Then E1 followed by 7 arbitrary bytes, then 29 -> only output is 0x20.
- Hold i_ascii_ready=0, send 1C then 32 -> o_ascii stays 0x61 with valid held, o_drop pulses once. Raise i_ascii_ready -> valid clears next cycle.
- Send F0, assert i_rst_n=0 for 2 cycles, release, send 1C -> output 0x61 and all outputs at reset values during reset.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code to ASCII decoder with make/break, E0/E1 prefix, Shift and lock tracking.
// One-deep valid/ready output register; 1-clock latency; a character decoded while stalled is dropped and flagged.
module ps2_scancode_decoder #(
   parameter int E1_SKIP = 7
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_scancode,
   input  logic       i_scan_valid,
   output logic [7:0] o_ascii,
   output logic       o_ascii_valid,
   input  logic       i_ascii_ready,
   output logic [2:0] o_led_status,
   output logic       o_drop
);

   localparam int CW = (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);

   typedef enum logic [2:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK,
      SKIP
   } state_t;

   state_t         state_q;
   logic           lshift_q;
   logic           rshift_q;
   logic [2:0]     held_q;
   logic [2:0]     led_q;
   logic [7:0]     ascii_q;
   logic           vld_q;
   logic           drop_q;
   logic [CW-1:0]  skip_q;

   logic           is_make;
   logic [2:0]     lock_hit;
   logic           shift;
   logic           caps;
   logic [7:0]     lc_d;
   logic [7:0]     dg_d;
   logic [7:0]     ds_d;
   logic [7:0]     fx_d;
   logic [7:0]     char_d;
   logic           char_vld_d;

   assign is_make  = i_scan_valid && (state_q == IDLE) &&
                     !(i_scancode inside {8'hE0, 8'hF0, 8'hE1});
   // Bit order matches o_led_status: [0]=Scroll, [1]=Num, [2]=Caps.
   assign lock_hit = {i_scancode == 8'h58, i_scancode == 8'h77, i_scancode == 8'h7E};
   assign shift    = lshift_q | rshift_q;
   assign caps     = led_q[2];

   always_comb begin
      lc_d = 8'h00;
      dg_d = 8'h00;
      ds_d = 8'h00;
      fx_d = 8'h00;
      case (i_scancode)
         8'h1C: lc_d = 8'h61;  8'h32: lc_d = 8'h62;  8'h21: lc_d = 8'h63;
         8'h23: lc_d = 8'h64;  8'h24: lc_d = 8'h65;  8'h2B: lc_d = 8'h66;
         8'h34: lc_d = 8'h67;  8'h33: lc_d = 8'h68;  8'h43: lc_d = 8'h69;
         8'h3B: lc_d = 8'h6A;  8'h42: lc_d = 8'h6B;  8'h4B: lc_d = 8'h6C;
         8'h3A: lc_d = 8'h6D;  8'h31: lc_d = 8'h6E;  8'h44: lc_d = 8'h6F;
         8'h4D: lc_d = 8'h70;  8'h15: lc_d = 8'h71;  8'h2D: lc_d = 8'h72;
         8'h1B: lc_d = 8'h73;  8'h2C: lc_d = 8'h74;  8'h3C: lc_d = 8'h75;
         8'h2A: lc_d = 8'h76;  8'h1D: lc_d = 8'h77;  8'h22: lc_d = 8'h78;
         8'h35: lc_d = 8'h79;  8'h1A: lc_d = 8'h7A;
         8'h16: begin dg_d = 8'h31; ds_d = 8'h21; end
         8'h1E: begin dg_d = 8'h32; ds_d = 8'h40; end
         8'h26: begin dg_d = 8'h33; ds_d = 8'h23; end
         8'h25: begin dg_d = 8'h34; ds_d = 8'h24; end
         8'h2E: begin dg_d = 8'h35; ds_d = 8'h25; end
         8'h36: begin dg_d = 8'h36; ds_d = 8'h5E; end
         8'h3D: begin dg_d = 8'h37; ds_d = 8'h26; end
         8'h3E: begin dg_d = 8'h38; ds_d = 8'h2A; end
         8'h46: begin dg_d = 8'h39; ds_d = 8'h28; end
         8'h45: begin dg_d = 8'h30; ds_d = 8'h29; end
         8'h29: fx_d = 8'h20;
         8'h5A: fx_d = 8'h0D;
         8'h66: fx_d = 8'h08;
         8'h0D: fx_d = 8'h09;
         8'h76: fx_d = 8'h1B;
         default: ;
      endcase
   end

   always_comb begin
      char_d = 8'h00;
      if (lc_d != 8'h00) begin
         char_d = (shift ^ caps) ? (lc_d - 8'h20) : lc_d;
      end else if (dg_d != 8'h00) begin
         char_d = shift ? ds_d : dg_d;
      end else begin
         char_d = fx_d;
      end
      char_vld_d = is_make && (char_d != 8'h00);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         held_q   <= 3'b000;
         led_q    <= 3'b000;
         ascii_q  <= 8'h00;
         vld_q    <= 1'b0;
         drop_q   <= 1'b0;
         skip_q   <= '0;
      end else begin
         drop_q <= 1'b0;
         // A fresh character may overwrite one that is leaving this same cycle.
         if (char_vld_d && (!vld_q || i_ascii_ready)) begin
            ascii_q <= char_d;
            vld_q   <= 1'b1;
         end else if (char_vld_d) begin
            drop_q <= 1'b1;
         end else if (vld_q && i_ascii_ready) begin
            vld_q <= 1'b0;
         end

         if (i_scan_valid) begin
            case (state_q)
               IDLE: begin
                  if (i_scancode == 8'hE0) begin
                     state_q <= EXT;
                  end else if (i_scancode == 8'hF0) begin
                     state_q <= BRK;
                  end else if (i_scancode == 8'hE1) begin
                     state_q <= (E1_SKIP == 0) ? IDLE : SKIP;
                     skip_q  <= CW'(E1_SKIP);
                  end else begin
                     if (i_scancode == 8'h12) lshift_q <= 1'b1;
                     if (i_scancode == 8'h59) rshift_q <= 1'b1;
                     led_q  <= led_q ^ (lock_hit & ~held_q);
                     held_q <= held_q | lock_hit;
                  end
               end
               BRK: begin
                  if (i_scancode == 8'h12) lshift_q <= 1'b0;
                  if (i_scancode == 8'h59) rshift_q <= 1'b0;
                  held_q  <= held_q & ~lock_hit;
                  state_q <= IDLE;
               end
               EXT: begin
                  state_q <= (i_scancode == 8'hF0) ? EXT_BRK : IDLE;
               end
               EXT_BRK: begin
                  state_q <= IDLE;
               end
               SKIP: begin
                  skip_q <= skip_q - 1'b1;
                  if (skip_q <= CW'(1)) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_ascii       = ascii_q;
   assign o_ascii_valid = vld_q;
   assign o_led_status  = led_q;
   assign o_drop        = drop_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: keyboard-level reference model checked every cycle.
module tb_ps2_scancode_decoder;

   logic       i_clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] sc    = 8'h00;
   logic       sv    = 1'b0;
   logic       rdy   = 1'b1;
   logic [7:0] o_ascii;
   logic       o_ascii_valid;
   logic [2:0] o_led_status;
   logic       o_drop;

   int total = 0;
   int bad   = 0;
   int dut_drops = 0;

   ps2_scancode_decoder #(.E1_SKIP(7)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (rst_n),
      .i_scancode    (sc),
      .i_scan_valid  (sv),
      .o_ascii       (o_ascii),
      .o_ascii_valid (o_ascii_valid),
      .i_ascii_ready (rdy),
      .o_led_status  (o_led_status),
      .o_drop        (o_drop)
   );

   always #5 i_clk = ~i_clk;

   // Reference keyboard state
   bit         m_ext, m_brk, m_ls, m_rs, m_vld, m_drop;
   int         m_skip;
   bit [2:0]   m_held, m_led;
   logic [7:0] m_asc;
   int         m_c;
   logic [7:0] delivered[$];

   logic [7:0] letter_code [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                    8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                    8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] digit_code  [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
   logic [7:0] digit_plain [10] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30};
   logic [7:0] digit_shift [10] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29};

   function automatic int lock_idx(input logic [7:0] b);
      if (b == 8'h58) return 2;
      if (b == 8'h77) return 1;
      if (b == 8'h7E) return 0;
      return -1;
   endfunction

   function automatic int char_of(input logic [7:0] b, input bit shift, input bit caps);
      for (int i = 0; i < 26; i++)
         if (letter_code[i] == b) return (shift ^ caps) ? (8'h41 + i) : (8'h61 + i);
      for (int i = 0; i < 10; i++)
         if (digit_code[i] == b) return shift ? int'(digit_shift[i]) : int'(digit_plain[i]);
      case (b)
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         8'h0D: return 8'h09;
         8'h76: return 8'h1B;
         default: return -1;
      endcase
   endfunction

   task automatic mstep(input logic [7:0] b, output int c);
      int li;
      c  = -1;
      li = lock_idx(b);
      if (m_skip > 0) begin
         m_skip--;
      end else if (m_ext) begin
         if (!m_brk && b == 8'hF0) m_brk = 1;
         else begin m_ext = 0; m_brk = 0; end
      end else if (m_brk) begin
         m_brk = 0;
         if (b == 8'h12) m_ls = 0;
         if (b == 8'h59) m_rs = 0;
         if (li >= 0) m_held[li] = 0;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else begin
         c = char_of(b, m_ls | m_rs, m_led[2]);
         if (b == 8'h12) m_ls = 1;
         if (b == 8'h59) m_rs = 1;
         if (li >= 0) begin
            if (!m_held[li]) m_led[li] = ~m_led[li];
            m_held[li] = 1;
         end
      end
   endtask

   always @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ext = 0; m_brk = 0; m_skip = 0; m_ls = 0; m_rs = 0;
         m_held = 0; m_led = 0; m_asc = 8'h00; m_vld = 0; m_drop = 0;
      end else begin
         m_c = -1;
         if (sv) mstep(sc, m_c);
         if (m_vld && rdy) delivered.push_back(m_asc);
         m_drop = (m_c >= 0) && m_vld && !rdy;
         if (m_c >= 0 && !m_drop) begin
            m_asc = m_c[7:0];
            m_vld = 1;
         end else if (m_c < 0 && m_vld && rdy) begin
            m_vld = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      chk("valid", 32'(o_ascii_valid), 32'(m_vld));
      chk("ascii", 32'(o_ascii), 32'(m_asc));
      chk("led",   32'(o_led_status), 32'(m_led));
      chk("drop",  32'(o_drop), 32'(m_drop));
      if (o_drop === 1'b1) dut_drops++;
   end

   task automatic send(input logic [7:0] b);
      @(posedge i_clk); #2;
      sc = b; sv = 1'b1;
      @(posedge i_clk); #2;
      sv = 1'b0;
      repeat (2) @(posedge i_clk);
   endtask

   task automatic send_seq(input logic [7:0] q[$]);
      foreach (q[i]) send(q[i]);
   endtask

   logic [7:0] exp_out [9] = '{8'h61, 8'h41, 8'h61, 8'h21, 8'h41, 8'h61, 8'h20, 8'h61, 8'h61};

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #2 rst_n = 1'b1;
      chk("reset_ascii", 32'(o_ascii), 32'h00);
      chk("reset_led", 32'(o_led_status), 32'h0);

      send_seq('{8'h1C, 8'hF0, 8'h1C});
      send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
      send_seq('{8'h59, 8'h16, 8'hF0, 8'h59});

      send_seq('{8'h58, 8'h58, 8'hF0, 8'h58});
      #1 chk("caps_led", 32'(o_led_status), 32'h4);
      send_seq('{8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12});

      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      #1 chk("ext_led", 32'(o_led_status), 32'h4);
      send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});
      #1 chk("skip_led", 32'(o_led_status), 32'h4);

      send_seq('{8'h58, 8'hF0, 8'h58});
      #1 chk("caps_off", 32'(o_led_status), 32'h0);

      @(posedge i_clk); #2 rdy = 1'b0;
      send_seq('{8'h1C, 8'h32});
      repeat (2) @(posedge i_clk);
      #1 chk("held_ascii", 32'(o_ascii), 32'h61);
      chk("held_valid", 32'(o_ascii_valid), 32'h1);
      @(posedge i_clk); #2 rdy = 1'b1;
      @(posedge i_clk); #2;
      chk("valid_clear", 32'(o_ascii_valid), 32'h0);

      send(8'hF0);
      @(posedge i_clk); #2 rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #2 rst_n = 1'b1;
      send(8'h1C);
      repeat (3) @(posedge i_clk);

      chk("drop_count", 32'(dut_drops), 32'd1);
      chk("delivered_n", 32'(delivered.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("delivered_%0d", i),
             (i < delivered.size()) ? 32'(delivered[i]) : 32'hFFFF, 32'(exp_out[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
